acct_table_shadow: RTL

- Parametrised access-control table for SoC peripherals.
- Software programs a shadow bank through a simple register port, then commits it to the active bank with a one-entry-per-cycle copy state machine.
- The active bank drives the permission vector `acc_ctrl_o` used by the peripheral crossbar.
- Adds over the previous generation: configurable entry count and width, sticky per-entry locks, atomic commit with a generation counter, and error responses.

---
 rtl/acct_table_shadow.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/acct_table_shadow.sv
// Shadow/active access-control table: software programs the shadow bank over a
// simple register port, then a commit copies it one entry per cycle into the active bank.
module acct_table_shadow #(
  parameter int unsigned           NB_ENTRIES = 10,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = {DATA_WIDTH{1'b1}}
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clear_i,
  input  logic                             req_i,
  input  logic                             we_i,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  output logic                             gnt_o,
  output logic                             rvalid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             err_o,
  input  logic [NB_ENTRIES-1:0]            reglk_wr_i,
  input  logic [NB_ENTRIES-1:0]            reglk_rd_i,
  output logic [NB_ENTRIES*DATA_WIDTH-1:0] acc_ctrl_o,
  output logic                             commit_done_o
);

  localparam int unsigned IW = ADDR_WIDTH - 2;
  localparam int unsigned EW = (NB_ENTRIES > 1) ? $clog2(NB_ENTRIES) : 1;

  localparam logic [IW-1:0] CTRL_IDX    = IW'(NB_ENTRIES);
  localparam logic [IW-1:0] LOCK_IDX    = IW'(NB_ENTRIES + 1);
  localparam logic [IW-1:0] ACT_LO_IDX  = IW'(NB_ENTRIES + 2);
  localparam logic [IW-1:0] ACT_END_IDX = IW'(2 * NB_ENTRIES + 2);
  localparam logic [EW-1:0] LAST_ENTRY  = EW'(NB_ENTRIES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COPY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [EW-1:0]           idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   shadow_q [NB_ENTRIES];
  logic [DATA_WIDTH-1:0]   shadow_d [NB_ENTRIES];
  logic [DATA_WIDTH-1:0]   active_q [NB_ENTRIES];
  logic [DATA_WIDTH-1:0]   active_d [NB_ENTRIES];
  logic [NB_ENTRIES-1:0]   lock_q, lock_d;
  logic [15:0]             gen_q, gen_d;
  logic                    rvalid_q, rvalid_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    done_q, done_d;

  logic [IW-1:0]           word_idx_s;
  logic [IW-1:0]           act_off_s;
  logic [EW-1:0]           sh_sel_s;
  logic [EW-1:0]           act_sel_s;
  logic                    is_shadow_s;
  logic                    is_ctrl_s;
  logic                    is_lock_s;
  logic                    is_active_s;
  logic [NB_ENTRIES-1:0]   eff_lock_s;
  logic                    busy_s;
  logic [DATA_WIDTH-1:0]   ctrl_word_s;
  logic                    unused_addr_s;

  assign word_idx_s    = addr_i[ADDR_WIDTH-1:2];
  assign act_off_s     = word_idx_s - ACT_LO_IDX;
  assign sh_sel_s      = EW'(word_idx_s);
  assign act_sel_s     = EW'(act_off_s);
  assign is_shadow_s   = (word_idx_s < CTRL_IDX);
  assign is_ctrl_s     = (word_idx_s == CTRL_IDX);
  assign is_lock_s     = (word_idx_s == LOCK_IDX);
  assign is_active_s   = (word_idx_s >= ACT_LO_IDX) && (word_idx_s < ACT_END_IDX);
  assign eff_lock_s    = reglk_wr_i | lock_q;
  assign busy_s        = (state_q != ST_IDLE);
  assign ctrl_word_s   = DATA_WIDTH'({gen_q, 14'd0, busy_s, 1'b0});
  assign unused_addr_s = ^addr_i[1:0];

  // Bus decode, commit sequencing and soft clear, all folded into next-state values.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    active_d = active_q;
    lock_d   = lock_q;
    gen_d    = gen_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          rvalid_d = 1'b1;
          if (we_i) begin
            if (is_shadow_s) begin
              if (eff_lock_s[sh_sel_s]) begin
                err_d = 1'b1;
              end else begin
                shadow_d[sh_sel_s] = wdata_i;
              end
            end else if (is_ctrl_s) begin
              if (wdata_i[0]) begin
                state_d = ST_COPY;
                idx_d   = '0;
              end else begin
                state_d = ST_IDLE;
              end
            end else if (is_lock_s) begin
              lock_d = lock_q | NB_ENTRIES'(wdata_i);
            end else begin
              err_d = 1'b1;
            end
          end else begin
            if (is_shadow_s) begin
              rdata_d = reglk_rd_i[sh_sel_s] ? '0 : shadow_q[sh_sel_s];
            end else if (is_ctrl_s) begin
              rdata_d = ctrl_word_s;
            end else if (is_lock_s) begin
              rdata_d = DATA_WIDTH'(lock_q);
            end else if (is_active_s) begin
              rdata_d = reglk_rd_i[act_sel_s] ? '0 : active_q[act_sel_s];
            end else begin
              err_d = 1'b1;
            end
          end
        end else begin
          rvalid_d = 1'b0;
        end
      end
      ST_COPY: begin
        // Locks are sampled per entry as it is copied, so late locks still protect later entries.
        if (!eff_lock_s[idx_q]) begin
          active_d[idx_q] = shadow_q[idx_q];
        end else begin
          active_d[idx_q] = active_q[idx_q];
        end
        if (idx_q == LAST_ENTRY) begin
          state_d = ST_DONE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = EW'(idx_q + 1'b1);
        end
      end
      ST_DONE: begin
        gen_d   = gen_q + 16'd1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    if (clear_i) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      lock_d   = '0;
      gen_d    = 16'd0;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      rdata_d  = '0;
      done_d   = 1'b0;
      for (int i = 0; i < NB_ENTRIES; i++) begin
        shadow_d[i] = RESET_VAL;
        active_d[i] = RESET_VAL;
      end
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      lock_q   <= '0;
      gen_q    <= 16'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < NB_ENTRIES; i++) begin
        shadow_q[i] <= RESET_VAL;
        active_q[i] <= RESET_VAL;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lock_q   <= lock_d;
      gen_q    <= gen_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  for (genvar g = 0; g < NB_ENTRIES; g++) begin : g_acc
    assign acc_ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = active_q[g];
  end

  assign gnt_o         = req_i && (state_q == ST_IDLE);
  assign rvalid_o      = rvalid_q;
  assign err_o         = err_q;
  assign rdata_o       = rdata_q;
  assign commit_done_o = done_q;

endmodule
